// File: rtl/cpu_if_pfq.sv
// -----------------------------------------------------------------------------
// cpu_if_pfq -- instruction fetch unit with a small prefetch queue
//
// Fetches one instruction word at a time from instruction memory and buffers
// {instruction, PC+4} pairs in a circular FIFO for the decode stage.
// Control transfers (redirects and interrupts) flush the queue and restart
// fetching at the new target.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          asynchronous, active-high reset
//   imem_req     request to instruction memory (held until imem_ack)
//   imem_addr    fetch address (byte address, word aligned, held with imem_req)
//   imem_ack     memory response valid (may arrive in the request cycle)
//   imem_rdata   instruction word returned with imem_ack
//   id_valid     queue head is valid
//   id_ready     decode accepts the head this cycle
//   id_ins       head instruction (zero when the queue is empty)
//   id_pca4      head PC+4 (zero when the queue is empty)
//   redir_valid  taken branch / jump / jr
//   redir_pc     redirect target
//   irq          level-sensitive interrupt request
//   iack         one-cycle interrupt accept pulse
//   epc          return PC captured on iack
// -----------------------------------------------------------------------------
module cpu_if_pfq #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [AW-1:0] INT_VEC  = 32'h0000_0080
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [DW-1:0] id_ins,
  output logic [AW-1:0] id_pca4,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  input  logic          irq,
  output logic          iack,
  output logic [AW-1:0] epc
);

  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] FOUR    = AW'(4);

  typedef enum logic [1:0] {
    S_BOOT    = 2'd0,
    S_FETCH   = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t        state_q,    state_d;
  logic [AW-1:0] fpc_q,      fpc_d;       // next address to fetch
  logic [AW-1:0] req_addr_q, req_addr_d;  // address of the outstanding request
  logic [AW-1:0] epc_q,      epc_d;
  logic          irq_blk_q,  irq_blk_d;   // interrupt re-entry guard
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;

  logic [DW-1:0] ins_mem  [DEPTH];
  logic [AW-1:0] pca4_mem [DEPTH];

  logic          q_empty;
  logic          ack_acc;
  logic          take_irq;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic          push;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Memory request side
  // ---------------------------------------------------------------------------
  // In FETCH nothing is outstanding, so occupancy+outstanding reduces to the
  // queue count. WAIT and DISCARD both hold the already-issued request.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fpc_q;
    case (state_q)
      S_FETCH: begin
        imem_req = (count_q < DEPTH_C);
      end
      S_WAIT, S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // An ack without a live request (BOOT, full queue, after reset) is noise.
  assign ack_acc = imem_ack && imem_req;

  // ---------------------------------------------------------------------------
  // Control transfers
  // ---------------------------------------------------------------------------
  assign q_empty  = (count_q == '0);
  assign take_irq = irq && !redir_valid && (state_q != S_BOOT) && !irq_blk_q;
  assign flush    = redir_valid || take_irq;
  assign flush_pc = redir_valid ? redir_pc : INT_VEC;

  // A flush wins over both queue operations in the same cycle. Data returning
  // for a request issued before a flush never reaches the queue.
  assign push = ack_acc && (state_q != S_DISCARD) && !flush;
  assign pop  = !q_empty && id_ready && !flush;

  // ---------------------------------------------------------------------------
  // Fetch FSM and fetch PC
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_req) begin
          req_addr_d = fpc_q;
          // A request issued in a flush cycle and not acked at once is still
          // owed a response, which must be swallowed.
          if (!ack_acc) begin
            state_d = flush ? S_DISCARD : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ack_acc) begin
          state_d = S_FETCH;
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (ack_acc) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    if (push) begin
      fpc_d = fpc_q + FOUR;
    end
    if (flush) begin
      fpc_d = flush_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt bookkeeping
  // ---------------------------------------------------------------------------
  // The guard is released by the first pop after the accept. The accept cycle
  // flushes, so that pop is the vector instruction (or, if another redirect
  // intervened, its target -- the guard must not outlive a lost vector).
  always_comb begin
    epc_d     = epc_q;
    irq_blk_d = irq_blk_q;
    if (take_irq) begin
      epc_d     = q_empty ? fpc_q : (id_pca4 - FOUR);
      irq_blk_d = 1'b1;
    end else if (pop) begin
      irq_blk_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fpc_q      <= RESET_PC;
      req_addr_q <= RESET_PC;
      epc_q      <= '0;
      irq_blk_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
      epc_q      <= epc_d;
      irq_blk_q  <= irq_blk_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset: the head fields are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_ptr_q]  <= imem_rdata;
      pca4_mem[wr_ptr_q] <= imem_addr + FOUR;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs
  // ---------------------------------------------------------------------------
  assign id_valid = !q_empty;
  assign id_ins   = q_empty ? '0 : ins_mem[rd_ptr_q];
  assign id_pca4  = q_empty ? '0 : pca4_mem[rd_ptr_q];
  assign iack     = take_irq;
  assign epc      = epc_q;

endmodule

// File: tb/tb_cpu_if_pfq.sv
// -----------------------------------------------------------------------------
// tb_cpu_if_pfq -- directed and randomized bench for cpu_if_pfq
//
// A reference model (queue of fetched entries, next-fetch PC, one outstanding
// request with a "to be dropped" flag) predicts every output each cycle.
// A memory responder with random latency supplies acks and data derived from
// the address. A second instance with a high reset PC checks address wrap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_if_pfq;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INT_VEC  = 32'h0000_0080;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pca4;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ins;
  logic [31:0] id_pca4;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        irq = 1'b0;
  logic        iack;
  logic [31:0] epc;

  logic        d2_req;
  logic [31:0] d2_addr;
  logic        d2_valid;
  logic [31:0] d2_ins;
  logic [31:0] d2_pca4;
  logic        d2_iack;
  logic [31:0] d2_epc;

  always #5 clk = ~clk;

  cpu_if_pfq #(
    .AW(32), .DW(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .INT_VEC(INT_VEC)
  ) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_ins(id_ins), .id_pca4(id_pca4),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .irq(irq), .iack(iack), .epc(epc)
  );

  // Zero-wait memory, always-ready decode: used only to observe address wrap.
  cpu_if_pfq #(
    .AW(32), .DW(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .INT_VEC(INT_VEC)
  ) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(d2_req), .imem_rdata(32'h0),
    .id_valid(d2_valid), .id_ready(1'b1), .id_ins(d2_ins), .id_pca4(d2_pca4),
    .redir_valid(1'b0), .redir_pc(32'h0),
    .irq(1'b0), .iack(d2_iack), .epc(d2_epc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // reference model
  bit          m_boot;
  bit          m_out;
  bit          m_drop;
  bit          m_blk;
  logic [31:0] m_fpc;
  logic [31:0] m_out_addr;
  logic [31:0] m_epc;
  ent_t        q[$];
  int          lat_left;
  int          lat_min;
  int          lat_max;
  bit          stray_en;

  // values observed in the most recent step
  logic        o_req, o_valid, o_iack, o_acc, o2_req;
  logic [31:0] o_addr, o_ins, o_pca4, o_epc, o2_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_out    = 1'b0;
    m_drop   = 1'b0;
    m_blk    = 1'b0;
    m_fpc    = RESET_PC;
    m_out_addr = RESET_PC;
    m_epc    = '0;
    lat_left = 0;
    q.delete();
  endtask

  // Called at a negedge; leaves rst released at a negedge.
  task automatic do_reset(input int ncyc);
    rst         = 1'b1;
    redir_valid = 1'b0;
    irq         = 1'b1;
    id_ready    = 1'b1;
    imem_ack    = 1'b1;
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      #1;
      chk("rst_req",   {31'b0, imem_req}, 32'd0);
      chk("rst_addr",  imem_addr, RESET_PC);
      chk("rst_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_ins",   id_ins, 32'd0);
      chk("rst_pca4",  id_pca4, 32'd0);
      chk("rst_iack",  {31'b0, iack}, 32'd0);
      chk("rst_epc",   epc, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rst      = 1'b0;
    irq      = 1'b0;
    imem_ack = 1'b0;
    $display("[%0t] reset released", $time);
  endtask

  // One clock cycle: drive inputs at negedge, check predictions, advance model.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy,
                      input logic irq_v, input logic ack_force);
    logic        p_req, p_valid, p_iack, acked, flush, pop;
    logic [31:0] p_addr, p_ins, p_pca4;
    ent_t        e;

    redir_valid = rv;
    redir_pc    = rpc;
    id_ready    = rdy;
    irq         = irq_v;

    p_req   = !m_boot && (m_out || (q.size() < DEPTH));
    p_addr  = m_out ? m_out_addr : m_fpc;
    p_valid = (q.size() != 0);
    p_ins   = p_valid ? q[0].ins  : 32'd0;
    p_pca4  = p_valid ? q[0].pca4 : 32'd0;
    p_iack  = irq_v && !rv && !m_boot && !m_blk;

    if (p_req && !m_out) lat_left = $urandom_range(lat_max, lat_min);
    if (ack_force) imem_ack = 1'b1;
    else if (p_req) imem_ack = (lat_left == 0);
    else imem_ack = stray_en && ($urandom_range(0, 3) == 0);
    imem_rdata = mem_word(p_addr);

    #1;
    chk("req",   {31'b0, imem_req}, {31'b0, p_req});
    chk("addr",  imem_addr, p_addr);
    chk("valid", {31'b0, id_valid}, {31'b0, p_valid});
    chk("ins",   id_ins, p_ins);
    chk("pca4",  id_pca4, p_pca4);
    chk("iack",  {31'b0, iack}, {31'b0, p_iack});
    chk("epc",   epc, m_epc);

    o_req = imem_req;  o_addr = imem_addr; o_valid = id_valid; o_ins = id_ins;
    o_pca4 = id_pca4;  o_iack = iack;      o_epc = epc;
    o_acc = imem_req && imem_ack;
    o2_req = d2_req;   o2_addr = d2_addr;

    acked = p_req && imem_ack;
    flush = rv || p_iack;
    pop   = p_valid && rdy && !flush;

    if (acked)
      $display("[%0t] ack addr=%h data=%h %s", $time, p_addr, mem_word(p_addr),
               (m_drop || flush) ? "dropped" : "queued");
    if (p_iack)
      $display("[%0t] iack epc<=%h", $time, p_valid ? (q[0].pca4 - 32'd4) : m_fpc);

    if (p_iack) begin
      m_epc = p_valid ? (q[0].pca4 - 32'd4) : m_fpc;
      m_blk = 1'b1;
    end else if (pop) begin
      m_blk = 1'b0;
    end

    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acked && !m_drop) begin
        e.ins  = mem_word(p_addr);
        e.pca4 = p_addr + 32'd4;
        q.push_back(e);
      end
    end

    if (acked && !m_drop && !flush) m_fpc = m_fpc + 32'd4;

    if (p_req && !imem_ack) begin
      if (!m_out) m_out_addr = p_addr;
      m_out = 1'b1;
      if (flush) m_drop = 1'b1;
      lat_left--;
    end else if (acked) begin
      m_out  = 1'b0;
      m_drop = 1'b0;
    end

    if (flush) m_fpc = rv ? rpc : INT_VEC;
    m_boot = 1'b0;

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout assertions=%0d failures=%0d", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_ack;
    int          n_iack;
    bit          found;
    int          irq_hold;
    logic        rv, rdy, iv;
    logic [31:0] rpc;

    lat_min  = 0;
    lat_max  = 0;
    stray_en = 1'b0;
    model_reset();
    @(negedge clk);

    // --- reset values, back-to-back zero-wait fetch, address wrap ---------
    do_reset(3);
    step(0, 0, 1, 0, 0);
    chk("boot_req", {31'b0, o_req}, 32'd0);
    chk("wrap_boot_req", {31'b0, o2_req}, 32'd0);
    step(0, 0, 1, 0, 0);
    chk("seq0_req", {31'b0, o_req}, 32'd1);
    chk("seq0_addr", o_addr, 32'h0);
    chk("wrap0_addr", o2_addr, 32'hFFFF_FFF8);
    step(0, 0, 1, 0, 0);
    chk("seq1_addr", o_addr, 32'h4);
    chk("seq1_pca4", o_pca4, 32'h4);
    chk("wrap1_addr", o2_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 0, 0);
    chk("seq2_addr", o_addr, 32'h8);
    chk("seq2_pca4", o_pca4, 32'h8);
    chk("wrap2_addr", o2_addr, 32'h0000_0000);
    chk("wrap2_req", {31'b0, o2_req}, 32'd1);
    step(0, 0, 1, 0, 0);
    chk("seq3_pca4", o_pca4, 32'hC);

    // --- decode stalled: fill, stop, one pop gives one refill -------------
    do_reset(2);
    n_ack = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_acc) n_ack++;
    end
    chk("fill_acks", n_ack, 32'd4);
    chk("full_req", {31'b0, o_req}, 32'd0);
    step(0, 0, 1, 0, 0);
    n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_acc) n_ack++;
    end
    chk("refill_acks", n_ack, 32'd1);
    chk("refill_req", {31'b0, o_req}, 32'd0);

    // --- redirect while a request waits ----------------------------------
    do_reset(2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lat_min = 5; lat_max = 5;
    step(0, 0, 0, 0, 0);
    chk("wait_addr", o_addr, 32'h8);
    step(0, 0, 0, 0, 0);
    step(1, 32'h100, 0, 0, 0);
    chk("pre_redir_valid", {31'b0, o_valid}, 32'd1);
    lat_min = 2; lat_max = 2;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_req && o_addr == 32'h100) found = 1'b1;
      else chk("discard_addr", o_addr, 32'h8);
      chk("discard_valid", {31'b0, o_valid}, 32'd0);
    end
    chk("redir_req_seen", {31'b0, found}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(0, 0, 0, 0, 0);
      if (o_valid) found = 1'b1;
    end
    chk("redir_data_seen", {31'b0, found}, 32'd1);
    chk("redir_pca4", o_pca4, 32'h104);
    chk("redir_ins", o_ins, mem_word(32'h100));

    // --- interrupt with head PC 0x40, level held -------------------------
    lat_min = 0; lat_max = 0;
    do_reset(2);
    step(0, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
    chk("irq_head", o_pca4, 32'h44);
    n_iack = 0;
    step(0, 0, 0, 1, 0);
    if (o_iack) n_iack++;
    chk("iack_pulse", {31'b0, o_iack}, 32'd1);
    step(0, 0, 0, 1, 0);
    if (o_iack) n_iack++;
    chk("epc_val", o_epc, 32'h40);
    chk("vec_addr", o_addr, INT_VEC);
    chk("vec_req", {31'b0, o_req}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      if (o_iack) n_iack++;
    end
    chk("vec_head", o_pca4, INT_VEC + 32'd4);
    step(0, 0, 1, 1, 0);
    if (o_iack) n_iack++;
    chk("iack_count", n_iack, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("epc_hold", o_epc, 32'h40);

    // --- reset during WAIT, ack at release -------------------------------
    do_reset(2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    lat_min = 6; lat_max = 6;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_wait_addr", o_addr, 32'h4);
    do_reset(2);
    lat_min = 0; lat_max = 0;
    step(0, 0, 0, 0, 1);
    chk("rel_req", {31'b0, o_req}, 32'd0);
    chk("rel_valid", {31'b0, o_valid}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("restart_addr", o_addr, RESET_PC);
    chk("restart_valid", {31'b0, o_valid}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("restart_pca4", o_pca4, RESET_PC + 32'd4);
    chk("restart_ins", o_ins, mem_word(RESET_PC));

    // --- randomized traffic against the model ----------------------------
    do_reset(2);
    stray_en = 1'b1;
    lat_min  = 0;
    lat_max  = 3;
    irq_hold = 0;
    for (int i = 0; i < 2000; i++) begin
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      rdy = ($urandom_range(0, 2) != 0);
      if (irq_hold == 0 && $urandom_range(0, 29) == 0) irq_hold = $urandom_range(1, 6);
      iv = (irq_hold != 0);
      if (irq_hold != 0) irq_hold--;
      if ($urandom_range(0, 499) == 0) begin
        do_reset($urandom_range(1, 3));
        irq_hold = 0;
      end else begin
        step(rv, rpc, rdy, iv, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
